// File: rtl/mini_alu_16bit_sub_serial.sv
// Bit-serial unsigned subtractor: diff = data0 + ~data1 + 1, STEP bits per clock,
// with valid/ready handshakes on both the operand and the result side.
module mini_alu_16bit_sub_serial #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             valid
);

   localparam int NCHUNK = WIDTH / STEP;
   localparam int CW     = $clog2(NCHUNK + 1) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One STEP-bit slice of the ripple sum; bit STEP is the carry out.
   function automatic logic [STEP:0] step_add(input logic [STEP-1:0] a,
                                              input logic [STEP-1:0] b,
                                              input logic            cin);
      step_add = {1'b0, a} + {1'b0, b} + {{STEP{1'b0}}, cin};
   endfunction

   state_t           state_r, state_s;
   logic [WIDTH-1:0] opa_r, opa_s;
   logic [WIDTH-1:0] opb_r, opb_s;
   logic             carry_r, carry_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] diff_r, diff_s;
   logic             borrow_r, borrow_s;
   logic             valid_r, valid_s;
   logic             in_ready_r, in_ready_s;
   logic             out_valid_r, out_valid_s;
   logic [STEP:0]    sum_s;
   logic [WIDTH-1:0] shift_s;

   // Next-state and next-value logic for the whole datapath.
   always_comb begin
      state_s     = state_r;
      opa_s       = opa_r;
      opb_s       = opb_r;
      carry_s     = carry_r;
      cnt_s       = cnt_r;
      diff_s      = diff_r;
      borrow_s    = borrow_r;
      valid_s     = valid_r;
      in_ready_s  = in_ready_r;
      out_valid_s = out_valid_r;
      sum_s       = step_add(opa_r[STEP-1:0], opb_r[STEP-1:0], carry_r);
      // opa doubles as the result accumulator: sum bits enter at the MSB end.
      shift_s     = (opa_r >> STEP) | (WIDTH'(sum_s[STEP-1:0]) << (WIDTH - STEP));

      case (state_r)
         IDLE: begin
            if (in_valid && in_ready_r) begin
               opa_s      = data0;
               opb_s      = ~data1;
               carry_s    = 1'b1;
               cnt_s      = {CW{1'b0}};
               in_ready_s = 1'b0;
               state_s    = CALC;
            end else begin
               in_ready_s = 1'b1;
            end
         end
         CALC: begin
            opa_s   = shift_s;
            opb_s   = opb_r >> STEP;
            carry_s = sum_s[STEP];
            cnt_s   = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
               diff_s      = shift_s;
               borrow_s    = ~sum_s[STEP];
               valid_s     = sum_s[STEP];
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               in_ready_s  = 1'b1;
               state_s     = IDLE;
            end else begin
               out_valid_s = 1'b1;
            end
         end
         default: begin
            state_s     = IDLE;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered output flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_r       <= {WIDTH{1'b0}};
         opb_r       <= {WIDTH{1'b0}};
         carry_r     <= 1'b1;
         cnt_r       <= {CW{1'b0}};
         diff_r      <= {WIDTH{1'b0}};
         borrow_r    <= 1'b0;
         valid_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         opa_r       <= opa_s;
         opb_r       <= opb_s;
         carry_r     <= carry_s;
         cnt_r       <= cnt_s;
         diff_r      <= diff_s;
         borrow_r    <= borrow_s;
         valid_r     <= valid_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign diff      = diff_r;
   assign borrow    = borrow_r;
   assign valid     = valid_r;

endmodule

// File: tb/tb_mini_alu_16bit_sub_serial.sv
// Directed bench for the serial subtractor: STEP=1 and STEP=4 instances on one clock.
module tb_mini_alu_16bit_sub_serial;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, borrow1, valid1;
   logic [15:0] data0_1, data1_1, diff1;
   logic        in_valid4, in_ready4, out_valid4, out_ready4, borrow4, valid4;
   logic [15:0] data0_4, data1_4, diff4;

   int checks   = 0;
   int failures = 0;

   mini_alu_16bit_sub_serial #(.WIDTH(16), .STEP(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .data0(data0_1), .data1(data1_1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .diff(diff1), .borrow(borrow1), .valid(valid1)
   );

   mini_alu_16bit_sub_serial #(.WIDTH(16), .STEP(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .data0(data0_4), .data1(data1_4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .borrow(borrow4), .valid(valid4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair for a single edge, then scramble the inputs.
   task automatic accept1(input logic [15:0] a, input logic [15:0] b);
      in_valid1 = 1'b1; data0_1 = a; data1_1 = b;
      tick();
      in_valid1 = 1'b0; data0_1 = 16'hDEAD; data1_1 = 16'hBEEF;
   endtask

   task automatic accept4(input logic [15:0] a, input logic [15:0] b);
      in_valid4 = 1'b1; data0_4 = a; data1_4 = b;
      tick();
      in_valid4 = 1'b0; data0_4 = 16'hDEAD; data1_4 = 16'hBEEF;
   endtask

   task automatic wait_out1(output int cyc);
      cyc = 0;
      while (!out_valid1 && cyc < 64) begin tick(); cyc++; end
   endtask

   task automatic wait_out4(output int cyc);
      cyc = 0;
      while (!out_valid4 && cyc < 64) begin tick(); cyc++; end
   endtask

   task automatic test_reset;
      tick();
      checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin failures++;
         $display("FAIL reset_flags1: in_ready=%b out_valid=%b expected 1 0", in_ready1, out_valid1); end
      checks++; if (diff1 !== 16'h0000 || borrow1 !== 1'b0 || valid1 !== 1'b0) begin failures++;
         $display("FAIL reset_result1: diff=%h borrow=%b valid=%b expected 0000 0 0", diff1, borrow1, valid1); end
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || diff4 !== 16'h0000) begin failures++;
         $display("FAIL reset_dut4: in_ready=%b out_valid=%b diff=%h expected 1 0 0000", in_ready4, out_valid4, diff4); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      int cyc;
      out_ready1 = 1'b1;
      accept1(16'h1234, 16'h0234);
      checks++; if (in_ready1 !== 1'b0) begin failures++;
         $display("FAIL basic_busy: in_ready=%b expected 0", in_ready1); end
      wait_out1(cyc);
      checks++; if (cyc !== 16) begin failures++;
         $display("FAIL basic_latency: got %0d expected 16", cyc); end
      checks++; if (diff1 !== 16'h1000 || borrow1 !== 1'b0 || valid1 !== 1'b1) begin failures++;
         $display("FAIL basic_result: diff=%h borrow=%b valid=%b expected 1000 0 1", diff1, borrow1, valid1); end
      tick();
      checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || diff1 !== 16'h1000) begin failures++;
         $display("FAIL basic_release: in_ready=%b out_valid=%b diff=%h expected 1 0 1000", in_ready1, out_valid1, diff1); end
   endtask

   task automatic test_underflow;
      logic [15:0] ta [2];
      logic [15:0] tb [2];
      logic [15:0] te [2];
      int cyc;
      ta = '{16'h0000, 16'h0000};
      tb = '{16'h0001, 16'hFFFF};
      te = '{16'hFFFF, 16'h0001};
      for (int i = 0; i < 2; i++) begin
         accept1(ta[i], tb[i]);
         wait_out1(cyc);
         checks++; if (cyc !== 16) begin failures++;
            $display("FAIL underflow_latency[%0d]: got %0d expected 16", i, cyc); end
         checks++; if (diff1 !== te[i] || borrow1 !== 1'b1 || valid1 !== 1'b0) begin failures++;
            $display("FAIL underflow_result[%0d]: diff=%h borrow=%b valid=%b expected %h 1 0", i, diff1, borrow1, valid1, te[i]); end
         tick();
      end
   endtask

   task automatic test_edge;
      logic [15:0] ta [2];
      logic [15:0] tb [2];
      logic [15:0] te [2];
      int cyc;
      ta = '{16'h8000, 16'hFFFF};
      tb = '{16'h8000, 16'h0000};
      te = '{16'h0000, 16'hFFFF};
      for (int i = 0; i < 2; i++) begin
         accept1(ta[i], tb[i]);
         wait_out1(cyc);
         checks++; if (diff1 !== te[i] || borrow1 !== 1'b0 || valid1 !== 1'b1 || cyc !== 16) begin failures++;
            $display("FAIL edge_result[%0d]: diff=%h borrow=%b valid=%b lat=%0d expected %h 0 1 16", i, diff1, borrow1, valid1, cyc, te[i]); end
         tick();
      end
   endtask

   task automatic test_backpressure;
      int cyc;
      out_ready1 = 1'b0;
      accept1(16'h9000, 16'h1000);
      wait_out1(cyc);
      checks++; if (cyc !== 16) begin failures++;
         $display("FAIL bp_latency: got %0d expected 16", cyc); end
      in_valid1 = 1'b1; data0_1 = 16'h5555; data1_1 = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin failures++;
            $display("FAIL bp_hold_flags[%0d]: out_valid=%b in_ready=%b expected 1 0", i, out_valid1, in_ready1); end
         checks++; if (diff1 !== 16'h8000 || borrow1 !== 1'b0 || valid1 !== 1'b1) begin failures++;
            $display("FAIL bp_hold_result[%0d]: diff=%h borrow=%b valid=%b expected 8000 0 1", i, diff1, borrow1, valid1); end
         tick();
      end
      out_ready1 = 1'b1;
      tick();
      checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin failures++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready1, out_valid1); end
      tick();
      in_valid1 = 1'b0; data0_1 = 16'hDEAD; data1_1 = 16'hBEEF;
      checks++; if (in_ready1 !== 1'b0) begin failures++;
         $display("FAIL bp_new_accept: in_ready=%b expected 0", in_ready1); end
      wait_out1(cyc);
      checks++; if (diff1 !== 16'h4444 || borrow1 !== 1'b0 || cyc !== 16) begin failures++;
         $display("FAIL bp_new_result: diff=%h borrow=%b lat=%0d expected 4444 0 16", diff1, borrow1, cyc); end
      tick();
   endtask

   task automatic test_reset_mid;
      int cyc;
      out_ready1 = 1'b1;
      accept1(16'h1234, 16'h0001);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || diff1 !== 16'h0000) begin failures++;
         $display("FAIL midreset_state: out_valid=%b in_ready=%b diff=%h expected 0 1 0000", out_valid1, in_ready1, diff1); end
      tick();
      accept1(16'h00FF, 16'h000F);
      wait_out1(cyc);
      checks++; if (cyc !== 16) begin failures++;
         $display("FAIL midreset_latency: got %0d expected 16", cyc); end
      checks++; if (diff1 !== 16'h00F0 || borrow1 !== 1'b0 || valid1 !== 1'b1) begin failures++;
         $display("FAIL midreset_result: diff=%h borrow=%b valid=%b expected 00f0 0 1", diff1, borrow1, valid1); end
      tick();
   endtask

   task automatic test_step4;
      int cyc;
      out_ready4 = 1'b1;
      accept4(16'hABCD, 16'h1234);
      wait_out4(cyc);
      checks++; if (cyc !== 4) begin failures++;
         $display("FAIL step4_latency: got %0d expected 4", cyc); end
      checks++; if (diff4 !== 16'h9999 || borrow4 !== 1'b0 || valid4 !== 1'b1) begin failures++;
         $display("FAIL step4_result: diff=%h borrow=%b valid=%b expected 9999 0 1", diff4, borrow4, valid4); end
      tick();
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin failures++;
         $display("FAIL step4_release: in_ready=%b out_valid=%b expected 1 0", in_ready4, out_valid4); end
   endtask

   task automatic test_back_to_back;
      int rises [3];
      int nrise;
      logic prev;
      nrise = 0; prev = 1'b0;
      out_ready4 = 1'b1;
      in_valid4 = 1'b1; data0_4 = 16'h0010; data1_4 = 16'h0001;
      for (int c = 0; c < 40 && nrise < 3; c++) begin
         tick();
         if (out_valid4 && !prev) begin
            rises[nrise] = c;
            nrise++;
            checks++; if (diff4 !== 16'h000F || borrow4 !== 1'b0) begin failures++;
               $display("FAIL b2b_result[%0d]: diff=%h borrow=%b expected 000f 0", nrise, diff4, borrow4); end
         end
         prev = out_valid4;
      end
      in_valid4 = 1'b0;
      checks++; if (nrise !== 3) begin failures++;
         $display("FAIL b2b_count: got %0d results expected 3", nrise); end
      if (nrise == 3) begin
         checks++; if (rises[1] - rises[0] !== 6 || rises[2] - rises[1] !== 6) begin failures++;
            $display("FAIL b2b_period: got %0d and %0d expected 6 6", rises[1] - rises[0], rises[2] - rises[1]); end
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   initial begin
      rst = 1'b1;
      in_valid1 = 1'b0; data0_1 = 16'h0000; data1_1 = 16'h0000; out_ready1 = 1'b1;
      in_valid4 = 1'b0; data0_4 = 16'h0000; data1_4 = 16'h0000; out_ready4 = 1'b1;
      test_reset();
      test_basic();
      test_underflow();
      test_edge();
      test_backpressure();
      test_reset_mid();
      test_step4();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
